// File: rtl/dense_mac_engine.sv
// Time-multiplexed dense layer: LANES MAC lanes sweep output groups, fusing bias, floor-shift, saturation and ReLU.
// Optional `define DENSE_ARGMAX_EN adds a class_idx output (argmax of the result vector, lowest index on ties).
module dense_mac_lane #(
  parameter int WIDTH     = 16,
  parameter int NFRAC     = 10,
  parameter int ACC_WIDTH = 37,
  parameter int RELU      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    mac_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] w_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] res_o
);
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum, shr;
  logic signed [2*WIDTH-1:0]   prod;

  assign prod = x_i * w_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)      acc_d = '0;
    else if (mac_i) acc_d = acc_q + {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  end

  // Bias is aligned to the product scale (2*NFRAC) before the floor shift.
  always_comb begin
    sum = acc_q + ({{(ACC_WIDTH-WIDTH){b_i[WIDTH-1]}}, b_i} <<< NFRAC);
    shr = sum >>> NFRAC;
    if (shr > SMAX)      res_o = SMAX[WIDTH-1:0];
    else if (shr < SMIN) res_o = SMIN[WIDTH-1:0];
    else                 res_o = shr[WIDTH-1:0];
    if (RELU != 0 && res_o[WIDTH-1]) res_o = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

module dense_mac_engine #(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 64,
  parameter int LANES       = 4,
  parameter int RELU        = 1,
  parameter logic [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1][WIDTH-1:0] WEIGHTS = '0,
  parameter logic [0:OUTPUT_SIZE-1][WIDTH-1:0]                 BIAS    = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]      input_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]     output_data
`ifdef DENSE_ARGMAX_EN
  ,
  output logic [$clog2(OUTPUT_SIZE)-1:0]        class_idx
`endif
);
  localparam int ACC_WIDTH = 2*WIDTH + $clog2(INPUT_SIZE) + 1;
  localparam int G  = OUTPUT_SIZE / LANES;
  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  if (OUTPUT_SIZE % LANES != 0) begin : g_bad_lanes
    $error("dense_mac_engine: LANES must divide OUTPUT_SIZE");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e                              state_q;
  logic                                in_ready_q, out_valid_q, wb_q;
  logic [IW-1:0]                       i_q;
  logic [GW-1:0]                       g_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]    x_q;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   out_q, out_d;
  logic signed [WIDTH-1:0]             lane_res [LANES];
  logic                                accept, mac, wb_fire;

  assign accept      = (state_q == IDLE) && in_valid;
  assign mac         = (state_q == COMPUTE) && !wb_q;
  assign wb_fire     = (state_q == COMPUTE) && wb_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign output_data = out_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] wcol [G][INPUT_SIZE];
    logic [WIDTH-1:0] bcol [G];
    for (genvar gg = 0; gg < G; gg++) begin : g_grp
      assign bcol[gg] = BIAS[gg*LANES+l];
      for (genvar ii = 0; ii < INPUT_SIZE; ii++) begin : g_in
        assign wcol[gg][ii] = WEIGHTS[ii][gg*LANES+l];
      end
      assign out_d[gg*LANES+l] = (wb_fire && g_q == GW'(gg)) ? lane_res[l] : out_q[gg*LANES+l];
    end
    dense_mac_lane #(.WIDTH(WIDTH), .NFRAC(NFRAC), .ACC_WIDTH(ACC_WIDTH), .RELU(RELU)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (accept || wb_fire),
      .mac_i (mac),
      .x_i   (x_q[i_q]),
      .w_i   (wcol[g_q][i_q]),
      .b_i   (bcol[g_q]),
      .res_o (lane_res[l])
    );
  end

`ifdef DENSE_ARGMAX_EN
  localparam int CW = $clog2(OUTPUT_SIZE);
  logic signed [WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]           idx_q, idx_d;

  // Lanes are scanned in index order with a strict compare, so ties keep the lowest index.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (accept) begin
      max_d = {1'b1, {(WIDTH-1){1'b0}}};
      idx_d = '0;
    end else if (wb_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_res[l] > max_d) begin
          max_d = lane_res[l];
          idx_d = CW'(g_q) * CW'(LANES) + CW'(l);
        end
      end
    end
  end
  assign class_idx = idx_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      i_q         <= '0;
      g_q         <= '0;
      x_q         <= '0;
      out_q       <= '0;
`ifdef DENSE_ARGMAX_EN
      max_q       <= '0;
      idx_q       <= '0;
`endif
    end else begin
      out_q <= out_d;
`ifdef DENSE_ARGMAX_EN
      max_q <= max_d;
      idx_q <= idx_d;
`endif
      case (state_q)
        IDLE: if (in_valid) begin
          x_q        <= input_data;
          i_q        <= '0;
          g_q        <= '0;
          wb_q       <= 1'b0;
          in_ready_q <= 1'b0;
          state_q    <= COMPUTE;
        end
        COMPUTE: if (!wb_q) begin
          if (i_q == IW'(INPUT_SIZE-1)) begin
            i_q  <= '0;
            wb_q <= 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end else begin
          wb_q <= 1'b0;
          if (g_q == GW'(G-1)) begin
            g_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            g_q <= g_q + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_mac_engine.sv
// Directed bench: four engines (identity+ReLU, identity linear, all-ones, upper-triangular 0.5) share one stimulus stream.
module tb_dense_mac_engine;
  localparam int W = 16, N = 4, M = 4, LN = 2;
  localparam logic [0:N-1][0:M-1][W-1:0] W_ID  = {16'd1024, 16'd0, 16'd0, 16'd0,
                                                 16'd0, 16'd1024, 16'd0, 16'd0,
                                                 16'd0, 16'd0, 16'd1024, 16'd0,
                                                 16'd0, 16'd0, 16'd0, 16'd1024};
  localparam logic [0:N-1][0:M-1][W-1:0] W_ONE = {16{16'd1024}};
  localparam logic [0:N-1][0:M-1][W-1:0] W_TRI = {16'd512, 16'd512, 16'd512, 16'd512,
                                                 16'd0, 16'd512, 16'd512, 16'd512,
                                                 16'd0, 16'd0, 16'd512, 16'd512,
                                                 16'd0, 16'd0, 16'd0, 16'd512};
  localparam logic [0:M-1][W-1:0] B_HALF = {4{16'd512}};
  localparam logic [0:M-1][W-1:0] B_ZERO = '0;

  typedef struct {
    int x[4];
    int e[4][4];
    int cls;
  } vec_t;

  logic clk, reset, in_valid, out_ready;
  logic [N-1:0][W-1:0] input_data;
  logic                ir [4];
  logic                ov [4];
  logic [M-1:0][W-1:0] od [4];
`ifdef DENSE_ARGMAX_EN
  logic [1:0]          cls [4];
`endif
  int passed = 0, total = 0;
  vec_t tv [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dense_mac_engine #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .LANES(LN), .RELU(1),
    .WEIGHTS(W_ID), .BIAS(B_HALF)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .input_data(input_data),
    .out_valid(ov[0]), .out_ready(out_ready), .output_data(od[0])
`ifdef DENSE_ARGMAX_EN
    , .class_idx(cls[0])
`endif
  );
  dense_mac_engine #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .LANES(LN), .RELU(0),
    .WEIGHTS(W_ID), .BIAS(B_HALF)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .input_data(input_data),
    .out_valid(ov[1]), .out_ready(out_ready), .output_data(od[1])
`ifdef DENSE_ARGMAX_EN
    , .class_idx(cls[1])
`endif
  );
  dense_mac_engine #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .LANES(LN), .RELU(0),
    .WEIGHTS(W_ONE), .BIAS(B_ZERO)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .input_data(input_data),
    .out_valid(ov[2]), .out_ready(out_ready), .output_data(od[2])
`ifdef DENSE_ARGMAX_EN
    , .class_idx(cls[2])
`endif
  );
  dense_mac_engine #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .LANES(LN), .RELU(0),
    .WEIGHTS(W_TRI), .BIAS(B_ZERO)) u_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .input_data(input_data),
    .out_valid(ov[3]), .out_ready(out_ready), .output_data(od[3])
`ifdef DENSE_ARGMAX_EN
    , .class_idx(cls[3])
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [M-1:0][W-1:0] want;
    int cyc;
    @(negedge clk);
    chk($sformatf("v%0d ready", id), 128'(ir[0]), 128'd1);
    for (int k = 0; k < N; k++) input_data[k] = 16'(v.x[k]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d latency", id), 128'(cyc), 128'd10);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < M; k++) want[k] = 16'(v.e[j][k]);
      chk($sformatf("v%0d out%0d", id, j), 128'(od[j]), 128'(want));
    end
`ifdef DENSE_ARGMAX_EN
    chk($sformatf("v%0d class_idx", id), 128'(cls[0]), 128'(v.cls));
`endif
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk(name, {ov[0], ir[0]}, 2'b01);
  endtask

  initial begin
    logic [M-1:0][W-1:0] save;
    logic                quiet;
    tv[0] = '{'{1024, -2048, 256, 3072},
              '{'{1536, 0, 768, 3584}, '{1536, -1536, 768, 3584},
                '{2304, 2304, 2304, 2304}, '{512, -512, -384, 1152}}, 3};
    tv[1] = '{'{31744, 31744, 31744, 31744},
              '{'{32256, 32256, 32256, 32256}, '{32256, 32256, 32256, 32256},
                '{32767, 32767, 32767, 32767}, '{15872, 31744, 32767, 32767}}, 0};
    tv[2] = '{'{-31744, -31744, -31744, -31744},
              '{'{0, 0, 0, 0}, '{-31232, -31232, -31232, -31232},
                '{-32768, -32768, -32768, -32768}, '{-15872, -31744, -32768, -32768}}, 0};
    tv[3] = '{'{0, 0, 0, 0},
              '{'{512, 512, 512, 512}, '{512, 512, 512, 512},
                '{0, 0, 0, 0}, '{0, 0, 0, 0}}, 0};
    tv[4] = '{'{-101, 32767, -32768, 5},
              '{'{411, 32767, 0, 517}, '{411, 32767, -32256, 517},
                '{-97, -97, -97, -97}, '{-51, 16333, -51, -49}}, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset out_valid", 128'(ov[0]), 128'd0);
    chk("reset in_ready", 128'(ir[0]), 128'd1);
    for (int j = 0; j < 4; j++) chk($sformatf("reset data%0d", j), 128'(od[j]), 128'd0);

    // Identity vector, then hold the result under backpressure while in_valid toggles.
    run_vec(tv[0], 0);
    save = od[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", c), {ov[0], ir[0], od[0]}, {1'b1, 1'b0, save});
      in_valid = c[0];
      input_data = {4{16'(c * 37 + 1)}};
    end
    @(negedge clk);
    chk("stall end", {ov[0], ir[0], od[0]}, {1'b1, 1'b0, save});
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("handshake", {ov[0], ir[0], od[0]}, {1'b0, 1'b1, save});
    @(negedge clk);
    chk("no capture", {ov[0], ir[0]}, 2'b01);

    for (int v = 1; v < 4; v++) begin
      run_vec(tv[v], v);
      release_out($sformatf("v%0d release", v));
    end

    // Reset five cycles into a vector aborts it.
    @(negedge clk);
    for (int k = 0; k < N; k++) input_data[k] = 16'(tv[1].x[k]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", 128'(ir[0]), 128'd1);
    for (int j = 0; j < 4; j++) chk($sformatf("abort data%0d", j), 128'(od[j]), 128'd0);
    quiet = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (ov[0] || ov[3]) quiet = 1'b0;
    end
    chk("abort no valid", 128'(quiet), 128'd1);
    run_vec(tv[4], 4);
    release_out("v4 release");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
